// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state type for the UART receive path.
//   OVERSAMPLE : baud ticks per bit period
//   MID_TICK   : tick count at the middle of the start bit
//   LAST_TICK  : tick count at the end of a full bit period
//   DATA_BITS  : payload width
package uart_pkg;

    localparam int          OVERSAMPLE = 16;
    localparam int          DATA_BITS  = 8;
    localparam logic [3:0]  MID_TICK   = 4'd7;
    localparam logic [3:0]  LAST_TICK  = 4'd15;
    localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/parity_generator.sv
// parity_generator: parity bit shared by the UART transmitter and receiver.
//   data_in    : payload byte
//   PARITYSEL  : 1 = odd parity, 0 = even parity
//   parity_out : parity bit that makes the frame match the selected mode
module parity_generator
    import uart_pkg::*;
(
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 PARITYSEL,
    output logic                 parity_out
);

    assign parity_out = PARITYSEL ? ~^data_in : ^data_in;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N+parity+1 serial receiver, 16x oversampled, mid-bit sampling.
//   clk, resetn  : system clock, asynchronous active-low reset
//   b_tick       : baud tick, 16 per bit, one clk wide
//   rx           : serial line (asynchronous, idles high)
//   PARITYSEL    : 1 = odd, 0 = even; latched at start detection
//   d_out        : last received byte
//   rx_done      : one-cycle strobe, d_out and flags updated this cycle
//   parity_err   : parity mismatch on last byte
//   frame_err    : stop bit sampled low on last byte
module uart_rx
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 b_tick,
    input  logic                 rx,
    input  logic                 PARITYSEL,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err
);

    // Two-flop synchroniser; resets to the idle line level.
    logic rx_meta_q, rx_s_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    uart_rx_state_t       state_q, state_d;
    logic [3:0]           b_q, b_d;
    logic [2:0]           n_q, n_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 par_sel_q, par_sel_d;
    logic [DATA_BITS-1:0] d_out_q, d_out_d;
    logic                 rx_done_q, rx_done_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 par_exp;

    parity_generator u_par (
        .data_in    (data_q),
        .PARITYSEL  (par_sel_q),
        .parity_out (par_exp)
    );

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        n_d       = n_q;
        data_d    = data_q;
        par_d     = par_q;
        par_sel_d = par_sel_q;
        d_out_d   = d_out_q;
        rx_done_d = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        case (state_q)
            IDLE: begin
                // Start edge needs no tick: the tick phase is then at most
                // one tick off, well inside the half-bit margin.
                if (!rx_s_q) begin
                    state_d   = START;
                    b_d       = 4'd0;
                    par_sel_d = PARITYSEL;
                end
            end
            START: begin
                if (b_tick) begin
                    if (b_q == MID_TICK) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            b_d     = 4'd0;
                            n_d     = 3'd0;
                        end else begin
                            state_d = IDLE;   // glitch, not a real start
                        end
                    end else begin
                        b_d = b_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (b_tick) begin
                    if (b_q == LAST_TICK) begin
                        data_d = {rx_s_q, data_q[DATA_BITS-1:1]};
                        b_d    = 4'd0;
                        if (n_q == LAST_BIT) state_d = PARITY;
                        else                 n_d     = n_q + 3'd1;
                    end else begin
                        b_d = b_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (b_tick) begin
                    if (b_q == LAST_TICK) begin
                        par_d   = rx_s_q;
                        b_d     = 4'd0;
                        state_d = STOP;
                    end else begin
                        b_d = b_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (b_tick) begin
                    if (b_q == LAST_TICK) begin
                        // Leave at mid stop bit so the next start edge is
                        // caught even with the sender running slightly fast.
                        d_out_d   = data_q;
                        perr_d    = (par_q != par_exp);
                        ferr_d    = ~rx_s_q;
                        rx_done_d = 1'b1;
                        b_d       = 4'd0;
                        state_d   = IDLE;
                    end else begin
                        b_d = b_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            b_q       <= 4'd0;
            n_q       <= 3'd0;
            data_q    <= '0;
            par_q     <= 1'b0;
            par_sel_q <= 1'b0;
            d_out_q   <= '0;
            rx_done_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            n_q       <= n_d;
            data_q    <= data_d;
            par_q     <= par_d;
            par_sel_q <= par_sel_d;
            d_out_q   <= d_out_d;
            rx_done_q <= rx_done_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign d_out      = d_out_q;
    assign rx_done    = rx_done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. A behavioural serial source drives
// rx on baud-tick boundaries; every rx_done is captured into a queue and
// compared against hand-computed bytes and flags.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       b_tick = 1'b0;
    logic       rx = 1'b1;
    logic       PARITYSEL = 1'b0;
    logic [7:0] d_out;
    logic       rx_done, parity_err, frame_err;

    int checks = 0;
    int failures = 0;

    uart_rx dut (
        .clk        (clk),
        .resetn     (resetn),
        .b_tick     (b_tick),
        .rx         (rx),
        .PARITYSEL  (PARITYSEL),
        .d_out      (d_out),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // One b_tick every 4 clocks, updated on the falling edge.
    int tick_div = 0;
    always @(negedge clk) begin
        tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
        b_tick   <= (tick_div == 3);
    end

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;
    rec_t rq[$];

    always @(negedge clk)
        if (rx_done === 1'b1) rq.push_back('{d_out, parity_err, frame_err});

    logic glitch_win = 1'b0;
    logic beyond_start = 1'b0;
    always @(negedge clk)
        if (glitch_win && dut.state_q != IDLE && dut.state_q != START)
            beyond_start <= 1'b1;

    initial begin
        #1ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (b_tick !== 1'b1);
        end
    endtask

    task automatic tx_bit(input logic v, input int nt);
        #1 rx = v;
        wait_ticks(nt);
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic stop, input int stop_len);
        tx_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) tx_bit(d[i], 16);
        tx_bit(p, 16);
        tx_bit(stop, stop_len);
    endtask

    task automatic chk_pop(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        rec_t r;
        if (rq.size() == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            r = rq.pop_front();
            chk({tag, "_d"},  32'(r.d),  32'(d));
            chk({tag, "_pe"}, 32'(r.pe), 32'(pe));
            chk({tag, "_fe"}, 32'(r.fe), 32'(fe));
        end
    endtask

    logic [7:0] b96;

    initial begin
        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_d_out", 32'(d_out), 32'h00);
        chk("rst_rx_done", 32'(rx_done), 32'h0);
        chk("rst_perr", 32'(parity_err), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        resetn = 1'b1;
        tx_bit(1'b1, 32);

        // Even mode, 0x55 (four ones, parity bit 0)
        PARITYSEL = 1'b0;
        send(8'h55, 1'b0, 1'b1, 16);
        chk("f55_cnt", 32'(rq.size()), 32'd1);
        chk_pop("f55", 8'h55, 1'b0, 1'b0);

        // Odd mode, 0xA5 with wrong parity bit 0
        PARITYSEL = 1'b1;
        send(8'hA5, 1'b0, 1'b1, 16);
        chk("fA5_cnt", 32'(rq.size()), 32'd1);
        chk_pop("fA5", 8'hA5, 1'b1, 1'b0);

        // Stop bit low for 12 ticks (covers the mid-stop sample), then idle
        PARITYSEL = 1'b0;
        send(8'h3C, 1'b0, 1'b0, 12);
        tx_bit(1'b1, 40);
        chk("f3C_cnt", 32'(rq.size()), 32'd1);
        chk_pop("f3C", 8'h3C, 1'b0, 1'b1);
        send(8'h01, 1'b1, 1'b1, 16);
        chk("f01_cnt", 32'(rq.size()), 32'd1);
        chk_pop("f01", 8'h01, 1'b0, 1'b0);

        // 4-tick glitch on idle line
        tx_bit(1'b1, 16);
        glitch_win = 1'b1;
        tx_bit(1'b0, 4);
        tx_bit(1'b1, 20);
        glitch_win = 1'b0;
        chk("glitch_cnt", 32'(rq.size()), 32'd0);
        chk("glitch_state", 32'(dut.state_q), 32'(IDLE));
        chk("glitch_beyond", 32'(beyond_start), 32'd0);
        chk("glitch_hold", 32'(d_out), 32'h01);

        // Back-to-back, even mode
        PARITYSEL = 1'b0;
        send(8'h00, 1'b0, 1'b1, 16);
        send(8'hFF, 1'b0, 1'b1, 16);
        send(8'h81, 1'b0, 1'b1, 16);
        chk("b2b_even_cnt", 32'(rq.size()), 32'd3);
        chk_pop("ev00", 8'h00, 1'b0, 1'b0);
        chk_pop("evFF", 8'hFF, 1'b0, 1'b0);
        chk_pop("ev81", 8'h81, 1'b0, 1'b0);

        // Back-to-back, odd mode
        PARITYSEL = 1'b1;
        send(8'h00, 1'b1, 1'b1, 16);
        send(8'hFF, 1'b1, 1'b1, 16);
        send(8'h81, 1'b1, 1'b1, 16);
        chk("b2b_odd_cnt", 32'(rq.size()), 32'd3);
        chk_pop("od00", 8'h00, 1'b0, 1'b0);
        chk_pop("odFF", 8'hFF, 1'b0, 1'b0);
        chk_pop("od81", 8'h81, 1'b0, 1'b0);

        // Reset in the middle of 0x96 data bits
        PARITYSEL = 1'b0;
        tx_bit(1'b1, 16);
        b96 = 8'h96;
        tx_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) tx_bit(b96[i], 16);
        #3 resetn = 1'b0;
        rx = 1'b1;
        #1;
        chk("abort_d_out", 32'(d_out), 32'h00);
        chk("abort_rx_done", 32'(rx_done), 32'h0);
        chk("abort_perr", 32'(parity_err), 32'h0);
        chk("abort_ferr", 32'(frame_err), 32'h0);
        chk("abort_state", 32'(dut.state_q), 32'(IDLE));
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        tx_bit(1'b1, 20);
        chk("abort_cnt", 32'(rq.size()), 32'd0);
        send(8'h69, 1'b0, 1'b1, 16);
        chk("f69_cnt", 32'(rq.size()), 32'd1);
        chk_pop("f69", 8'h69, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that consumes the RS-232 line driven by the team's UART transmitter: one start bit, 8 data bits LSB first, one parity bit, one stop bit. Uses the same 16x `b_tick` baud-tick generator. It recovers each byte by mid-bit sampling, checks parity against `PARITYSEL`, flags framing errors, and presents the byte with a one-cycle `rx_done` strobe to the bus-side register block.

## Interface
- No parameters. Oversample ratio 16 and data width 8 are fixed package constants.

- `clk` input 1: system clock.
- `resetn` input 1: reset, asynchronous, active-low.
- `b_tick` input 1: baud tick, 16 per bit period, one `clk` wide.
- `rx` input 1: serial line, asynchronous to `clk`, idles high.
- `PARITYSEL` input 1: parity mode, 1 = odd, 0 = even. Same meaning as on the transmitter.
- `d_out` output 8: last received byte.
- `rx_done` output 1: one-cycle strobe; a new byte and its flags are valid.
- `parity_err` output 1: received parity bit mismatched for the last byte.
- `frame_err` output 1: stop bit sampled low for the last byte.

## Operation
- Synchronise `rx` through 2 flops, reset value 1. All decisions use the synchronised value `rx_s`.
- States:
  - **IDLE**: when `rx_s`==0, go to START; clear tick counter `b`; latch `PARITYSEL` into `par_sel_q`.
  - **START**: on `b_tick`, if `b`==7 (mid start bit): if `rx_s`==0, go to DATA with `b`=0 and `n`=0; otherwise it is a false start, return to IDLE. Otherwise `b`++.
  - **DATA**: on `b_tick`, if `b`==15: shift `data_reg` = {`rx_s`, `data_reg[7:1]`}, set `b`=0; if `n`==7 go to PARITY, else `n`++. Otherwise `b`++.
  - **PARITY**: on `b_tick`, if `b`==15: capture `par_q`=`rx_s`, set `b`=0, go to STOP. Otherwise `b`++.
  - **STOP**: on `b_tick`, if `b`==15: sample the stop bit, load the outputs, pulse `rx_done`, go to IDLE. Otherwise `b`++.
- Sampling points: mid start bit, then every 16 ticks, which lands each sample at the middle of its bit.
- Expected parity is ^`data_reg` for even mode and ~^`data_reg` for odd mode. `parity_err` = (`par_q` != expected).
- `frame_err` = ~`rx_s` at the stop sample.
- Outputs are loaded together on the stop-sample tick and hold until the next `rx_done`. A byte with an error is still delivered, with its flag set.
- No counting without `b_tick`: state, `b` and `n` hold.
- `PARITYSEL` changes mid-frame are ignored because `par_sel_q` is used.
- Frame with `frame_err`: return to IDLE anyway. If the line is still low, IDLE detects a new start (break behaves as repeated framing errors).

## Timing
- Reset values: `d_out`=0x00, `rx_done`=0, `parity_err`=0, `frame_err`=0, state IDLE, `b`=0, `n`=0, synchroniser=1.
- `resetn` low mid-frame aborts the frame immediately and asynchronously. No `rx_done` is produced for the partial byte.
- Input latency: 2 `clk` cycles through the synchroniser.
- `rx_done` is high for exactly the one `clk` cycle after the stop-sample `b_tick`. `d_out` and both flags change in that same cycle.
- Frame end: `rx_done` occurs 7+16*10 = 167 ticks after start detection, i.e. mid stop bit. The receiver is back in IDLE half a bit early to absorb baud skew.
- Back-to-back frames from the transmitter (stop bit directly followed by start bit) are received without loss.
- There is no flow control. The consumer must take `d_out` before the next `rx_done`.

## Structure
- Package `uart_pkg`:
  - state enum `uart_rx_state_t` {IDLE, START, DATA, PARITY, STOP};
  - constants `OVERSAMPLE`=16, `MID_TICK`=7, `LAST_TICK`=15, `DATA_BITS`=8.
- Sub-module: instantiate the existing `parity_generator` (`data_in`=`data_reg`, `PARITYSEL`=`par_sel_q`) to compute the expected parity bit. The transmitter and receiver then share one parity definition.
- Remaining logic: one FSM with registered state/counters and a combinational next-state block.

## Test plan
- Even mode, frame 0x55 with parity bit 0 and stop bit 1 → one `rx_done`, `d_out`=0x55, `parity_err`=0, `frame_err`=0.
- Odd mode, frame 0xA5 with parity bit 0 (correct bit is 1) → `d_out`=0xA5, `parity_err`=1, `frame_err`=0.
- Frame 0x3C with stop bit driven 0 → `d_out`=0x3C, `frame_err`=1. After the line returns high, the next frame 0x01 is received clean.
- 4-tick low glitch on an idle line → no `rx_done`, FSM back in IDLE, no state change beyond START.
- Loopback: transmitter sends 0x00, 0xFF, 0x81 back-to-back in both parity modes → three `rx_done` pulses, bytes matching in order, all flags 0.
- `resetn` pulsed low during the data bits of 0x96 → outputs stay at reset values with no `rx_done`. The following frame 0x69 is received correctly.
